e203_tb_irq_injector: RTL and testbench

//  Commit-stream-driven interrupt stimulus engine for the E203 SoC bench.
//  - Watches the ALU commit port (valid + PC) and arms after a configurable PC commits.
//  - Raises one IRQ line after a pseudo-random delay, then holds it until the handler's pre-MRET PC commits.
//  - Retires after a configurable number of tohost-PC commits.
//  - Sits between the commit port it observes and the PLIC/CLINT irq net it drives.
//  - One instance per line: ext, sft, tmr. Replaces ad-hoc bench force loops with a deterministic, seedable block.

---
 rtl/e203_tb_irq_injector.sv | 151 +++++++++++++++
 tb/tb_e203_tb_irq_injector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_tb_irq_injector.sv
// Commit-stream-driven interrupt stimulus engine. Arms on the first ARM_PC
// commit, raises irq_o after a pseudo-random delay, holds it until the
// handler's pre-MRET PC commits (or a timeout expires), and retires once
// enough TOHOST_PC commits have been seen.
module e203_tb_irq_injector #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] ARM_PC     = 32'h8000015C,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h800000A6,
  parameter logic [PC_W-1:0] TOHOST_PC  = 32'h80000086,
  parameter int unsigned     STOP_CNT   = 32,
  parameter int unsigned     MIN_DLY    = 1,
  parameter int unsigned     DLY_W      = 10,
  parameter logic [15:0]     SEED       = 16'hACE1,
  parameter int unsigned     TIMEOUT    = 4096
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            cmt_valid_i,
  input  logic [PC_W-1:0] cmt_pc_i,
  output logic            irq_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     inject_cnt_o,
  output logic [31:0]     tohost_cnt_o,
  output logic            timeout_err_o
);

  // Delay counter must hold MIN_DLY + (2^DLY_W - 1); wait counter holds TIMEOUT-1.
  localparam int unsigned DCNT_W = $clog2(MIN_DLY + (1 << DLY_W)) + 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ASSERT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                irq_q, irq_d;
  logic [31:0]         inject_q, inject_d;
  logic [31:0]         tohost_q, tohost_d;
  logic                err_q, err_d;

  logic                arm_hit, hdl_hit, toh_hit;
  logic                stop;
  logic                timeout;
  logic [15:0]         lfsr_next;
  logic [DCNT_W-1:0]   dly_load;

  // A PC only counts as a hit when the commit is valid.
  assign arm_hit = cmt_valid_i && (cmt_pc_i == ARM_PC);
  assign hdl_hit = cmt_valid_i && (cmt_pc_i == HANDLER_PC);
  assign toh_hit = cmt_valid_i && (cmt_pc_i == TOHOST_PC);

  // Retirement is decided from the registered tohost count.
  assign stop    = tohost_q > 32'(STOP_CNT);
  assign timeout = wcnt_q == WCNT_W'(TIMEOUT - 1);

  // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign dly_load  = DCNT_W'(MIN_DLY) + DCNT_W'(lfsr_q[DLY_W-1:0]);

  // Next-state, counter and IRQ decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    wcnt_d   = wcnt_q;
    inject_d = inject_q;
    err_d    = err_q;
    lfsr_d   = enable_i ? lfsr_next : lfsr_q;
    tohost_d = (toh_hit && (tohost_q != 32'hFFFF_FFFF)) ? tohost_q + 32'd1 : tohost_q;

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm_hit) begin
            dcnt_d  = dly_load;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dcnt_q == DCNT_W'(1)) begin
            state_d = stop ? ST_DONE : ST_ASSERT;
            wcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - DCNT_W'(1);
          end
        end
        ST_ASSERT: begin
          // Handler takes priority over a simultaneous timeout.
          if (hdl_hit || timeout) begin
            if (hdl_hit) inject_d = inject_q + 32'd1;
            else         err_d    = 1'b1;
            dcnt_d  = dly_load;
            state_d = stop ? ST_DONE : ST_DELAY;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    irq_d = (state_d == ST_ASSERT);
  end

  // State and counter registers; async reset drops irq_o immediately.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      dcnt_q   <= '0;
      wcnt_q   <= '0;
      irq_q    <= 1'b0;
      inject_q <= '0;
      tohost_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      irq_q    <= irq_d;
      inject_q <= inject_d;
      tohost_q <= tohost_d;
      err_q    <= err_d;
    end
  end

  assign irq_o         = irq_q;
  assign busy_o        = (state_q == ST_ASSERT);
  assign done_o        = (state_q == ST_DONE);
  assign inject_cnt_o  = inject_q;
  assign tohost_cnt_o  = tohost_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_e203_tb_irq_injector.sv
// Bench for e203_tb_irq_injector: directed vector table, hand-written corner
// sequences, and randomized commit streams against a timestamp-based model.
module tb_e203_tb_irq_injector;

  localparam logic [31:0] ARM      = 32'h8000015C;
  localparam logic [31:0] HDL      = 32'h800000A6;
  localparam logic [31:0] TOH      = 32'h80000086;
  localparam int unsigned STOP_CNT = 2;
  localparam int unsigned MIN_DLY  = 1;
  localparam int unsigned DLY_W    = 4;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int unsigned TIMEOUT  = 16;

  logic        hfclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        cmt_valid_i = 1'b0;
  logic [31:0] cmt_pc_i = '0;
  logic        irq_o, busy_o, done_o, timeout_err_o;
  logic [31:0] inject_cnt_o, tohost_cnt_o;

  e203_tb_irq_injector #(
    .PC_W(32), .ARM_PC(ARM), .HANDLER_PC(HDL), .TOHOST_PC(TOH),
    .STOP_CNT(STOP_CNT), .MIN_DLY(MIN_DLY), .DLY_W(DLY_W),
    .SEED(SEED), .TIMEOUT(TIMEOUT)
  ) dut (
    .hfclk(hfclk), .rst_n(rst_n), .enable_i(enable_i),
    .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i),
    .irq_o(irq_o), .busy_o(busy_o), .done_o(done_o),
    .inject_cnt_o(inject_cnt_o), .tohost_cnt_o(tohost_cnt_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 hfclk = ~hfclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (absolute-time view) ----------------
  typedef enum {P_IDLE, P_WAIT, P_IRQ, P_DONE} phase_e;
  phase_e      m_phase;
  longint      m_cyc, m_rise_at, m_deadline;
  logic [15:0] m_lfsr;
  logic [31:0] m_tohost, m_inject;
  logic        m_err;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_cyc = 0; m_rise_at = 0; m_deadline = 0;
    m_lfsr = SEED; m_tohost = '0; m_inject = '0; m_err = 1'b0;
  endtask

  // After an acknowledged or timed-out IRQ: retire, or schedule the next one.
  task automatic model_after_irq(input bit stop, input longint dly);
    if (stop) m_phase = P_DONE;
    else begin
      m_phase = P_WAIT;
      m_rise_at = m_cyc + dly;
    end
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [31:0] pc);
    bit     stop;
    longint dly;
    logic [15:0] cur;
    m_cyc++;
    stop = (m_tohost > STOP_CNT);
    cur  = m_lfsr;
    dly  = MIN_DLY + longint'(cur[DLY_W-1:0]);
    if (!en) m_phase = P_IDLE;
    else begin
      case (m_phase)
        P_IDLE: if (v && pc == ARM) begin
          m_phase = P_WAIT;
          m_rise_at = m_cyc + dly;
        end
        P_WAIT: if (m_cyc == m_rise_at) begin
          if (stop) m_phase = P_DONE;
          else begin
            m_phase = P_IRQ;
            m_deadline = m_cyc + TIMEOUT;
          end
        end
        P_IRQ: begin
          if (v && pc == HDL) begin
            m_inject++;
            model_after_irq(stop, dly);
          end else if (m_cyc == m_deadline) begin
            m_err = 1'b1;
            model_after_irq(stop, dly);
          end
        end
        default: ;
      endcase
    end
    if (v && pc == TOH && m_tohost != 32'hFFFF_FFFF) m_tohost++;
    if (en) m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".irq"},    irq_o,         (m_phase == P_IRQ));
    check({tag, ".busy"},   busy_o,        (m_phase == P_IRQ));
    check({tag, ".done"},   done_o,        (m_phase == P_DONE));
    check({tag, ".inject"}, inject_cnt_o,  m_inject);
    check({tag, ".tohost"}, tohost_cnt_o,  m_tohost);
    check({tag, ".err"},    timeout_err_o, m_err);
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic en, input logic v, input logic [31:0] pc, input string tag = "step");
    enable_i = en; cmt_valid_i = v; cmt_pc_i = pc;
    @(posedge hfclk);
    model_edge(en, v, pc);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable_i = 1'b0; cmt_valid_i = 1'b0; cmt_pc_i = '0;
    model_reset();
    #1;
    compare_model("reset");
    repeat (2) @(posedge hfclk);
    @(negedge hfclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 40 && m_phase != P_IRQ; i++) step(1'b1, 1'b0, 32'h0, tag);
    check({tag, ".irq_seen"}, irq_o, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          reps;
    logic        en;
    logic        v;
    logic [31:0] pc;
    logic        irq;
    logic        busy;
    logic        done;
    logic [31:0] inj;
    logic [31:0] toh;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // lfsr stays at SEED while disabled, so ARM sees lfsr[3:0]=1 -> dly=2.
    // At the ack edge lfsr=16'h389C -> dly=13; timeout fires TIMEOUT cycles after rise.
    vecs[0] = '{1,  1'b1, 1'b1, ARM,   1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "arm"};
    vecs[1] = '{1,  1'b1, 1'b1, ARM,   1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "arm_ignored_in_delay"};
    vecs[2] = '{1,  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "rise"};
    vecs[3] = '{1,  1'b1, 1'b1, HDL,   1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, "ack"};
    vecs[4] = '{12, 1'b1, 1'b1, HDL,   1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, "hdl_ignored_in_delay"};
    vecs[5] = '{1,  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 1'b0, "rise2"};
    vecs[6] = '{15, 1'b1, 1'b0, HDL,   1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 1'b0, "hold_invalid_hdl"};
    vecs[7] = '{1,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, "timeout"};

    do_reset();
    check("reset.irq", irq_o, 1'b0);
    check("reset.inject", inject_cnt_o, 32'd0);
    repeat (10) step(1'b0, 1'b0, 32'h0, "pre_arm");

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].en, vecs[i].v, vecs[i].pc, vecs[i].name);
        check({vecs[i].name, ".t_irq"},    irq_o,         vecs[i].irq);
        check({vecs[i].name, ".t_busy"},   busy_o,        vecs[i].busy);
        check({vecs[i].name, ".t_done"},   done_o,        vecs[i].done);
        check({vecs[i].name, ".t_inject"}, inject_cnt_o,  vecs[i].inj);
        check({vecs[i].name, ".t_tohost"}, tohost_cnt_o,  vecs[i].toh);
        check({vecs[i].name, ".t_err"},    timeout_err_o, vecs[i].err);
      end
    end

    // Handler commit on the very edge the timeout would fire: handler wins.
    do_reset();
    step(1'b1, 1'b1, ARM, "tie_arm");
    wait_irq("tie");
    for (int i = 0; i < int'(TIMEOUT) + 4 && (m_cyc + 1) < m_deadline; i++)
      step(1'b1, 1'b0, 32'h0, "tie_hold");
    step(1'b1, 1'b1, HDL, "tie_hit");
    check("tie.err", timeout_err_o, 1'b0);
    check("tie.inject", inject_cnt_o, 32'd1);
    check("tie.irq", irq_o, 1'b0);

    // Stop threshold crossed during ASSERT: handshake completes, then DONE.
    do_reset();
    step(1'b1, 1'b1, ARM, "stop_arm");
    wait_irq("stop");
    repeat (3) step(1'b1, 1'b1, TOH, "stop_toh");
    check("stop.irq_held", irq_o, 1'b1);
    check("stop.tohost3", tohost_cnt_o, 32'd3);
    step(1'b1, 1'b1, HDL, "stop_ack");
    check("stop.irq_drop", irq_o, 1'b0);
    check("stop.done", done_o, 1'b1);
    check("stop.inject", inject_cnt_o, 32'd1);
    repeat (2) step(1'b1, 1'b1, TOH, "done_toh");
    step(1'b1, 1'b1, ARM, "done_arm");
    check("done.tohost5", tohost_cnt_o, 32'd5);
    check("done.irq", irq_o, 1'b0);
    check("done.still_done", done_o, 1'b1);

    // enable_i dropped mid-DELAY: back to IDLE, no IRQ without a new ARM.
    do_reset();
    begin
      logic seen;
      seen = 1'b0;
      step(1'b1, 1'b1, ARM, "en_arm");
      step(1'b0, 1'b0, 32'h0, "en_off");
      check("en_off.busy", busy_o, 1'b0);
      for (int i = 0; i < 20; i++) begin
        step(1'b1, 1'b0, 32'h0, "en_back");
        seen = seen | irq_o;
      end
      check("en_off.no_irq", seen, 1'b0);
    end

    // Async reset mid-ASSERT with nonzero counters.
    do_reset();
    step(1'b1, 1'b1, ARM, "ar_arm");
    wait_irq("ar1");
    step(1'b1, 1'b1, HDL, "ar_ack");
    wait_irq("ar2");
    step(1'b1, 1'b1, TOH, "ar_toh");
    check("ar.pre_irq", irq_o, 1'b1);
    check("ar.pre_inject", inject_cnt_o, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar.irq", irq_o, 1'b0);
    check("ar.busy", busy_o, 1'b0);
    check("ar.inject", inject_cnt_o, 32'd0);
    check("ar.tohost", tohost_cnt_o, 32'd0);
    @(negedge hfclk);
    rst_n = 1'b1;

    // Randomized commit streams.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        logic        en, v;
        logic [31:0] pc;
        int unsigned sel;
        en  = ($urandom_range(0, 99) < 95);
        v   = ($urandom_range(0, 1) == 1);
        sel = $urandom_range(0, 99);
        if (sel < 15)                pc = ARM;
        else if (sel < 45)           pc = HDL;
        else if (sel < 48 && en)     pc = TOH;
        else                         pc = $urandom() | 32'h1;
        step(en, v, pc, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
